// File: rtl/gate_bist_pkg.sv
// Shared widths, feedback taps and state encoding for the gate BIST controller.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package gate_bist_pkg;

  localparam int IN_W  = 21;
  localparam int OUT_W = 10;

  // Pattern LFSR feedback x^21 + x^19 + 1: XOR of bits 20 and 18.
  localparam logic [IN_W-1:0]  LFSR_TAPS = 21'h140000;
  // MISR feedback: XOR of bits 9 and 6.
  localparam logic [OUT_W-1:0] MISR_TAPS = 10'h240;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // One MISR step: shift with feedback, then fold in the response word.
  function automatic logic [OUT_W-1:0] misr_next(input logic [OUT_W-1:0] sig,
                                                 input logic [OUT_W-1:0] resp);
    return {sig[OUT_W-2:0], ^(sig & MISR_TAPS)} ^ resp;
  endfunction

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Control/observe bundle between the BIST controller and its harness.
// Latency: n/a (wires only).
// Backpressure: none; start/abort are single-cycle pulses.
interface gate_bist_ctrl_if #(
  parameter int CNT_W = 10
);

  logic                             start;
  logic                             abort;
  logic [gate_bist_pkg::OUT_W-1:0]  golden;
  logic [gate_bist_pkg::OUT_W-1:0]  resp_in;
  logic [gate_bist_pkg::IN_W-1:0]   pat_out;
  logic                             busy;
  logic                             done;
  logic                             pass;
  logic [gate_bist_pkg::OUT_W-1:0]  signature;
  logic [CNT_W-1:0]                 pat_cnt;

  // Harness side: drives control and the DUT response, watches results.
  modport master (
    output start, abort, golden, resp_in,
    input  pat_out, busy, done, pass, signature, pat_cnt
  );

  // Controller side.
  modport slave (
    input  start, abort, golden, resp_in,
    output pat_out, busy, done, pass, signature, pat_cnt
  );

endinterface

// File: rtl/gate_bist_lfsr.sv
// Generic Fibonacci shift register with parallel XOR input (LFSR when xin=0, MISR otherwise).
// Latency: one cycle from en/load to q.
// Backpressure: none; en stalls the register, load reseeds it.
module gate_bist_lfsr #(
  parameter int            W    = 21,
  parameter logic [W-1:0]  TAPS = '0,
  parameter logic [W-1:0]  SEED = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [W-1:0]  xin,
  output logic [W-1:0]  q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next state: load has priority over a shift step; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = SEED;
    end else if (en) begin
      q_d = {q_q[W-2:0], ^(q_q & TAPS)} ^ xin;
    end
  end

  // Register with synchronous reset back to the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller: drives LFSR patterns into a combinational gate model and compacts its outputs in a MISR.
// Latency: a run takes exactly PATTERNS cycles in RUN; all outputs are registered.
// Backpressure: none; start is ignored while running, abort returns to IDLE at the next edge.
module gate_bist_ctrl import gate_bist_pkg::*; #(
  parameter int               PATTERNS = 1000,
  parameter logic [IN_W-1:0]  SEED     = 21'h000001,
  parameter int               CNT_W    = $clog2(PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  gate_bist_ctrl_if.slave  bus
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [IN_W-1:0]  SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PATTERNS - 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_RUN  = 2'(RUN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             init;
  logic             step;
  logic [IN_W-1:0]  pat_q;
  logic [OUT_W-1:0] sig_q;

  // FSM, counter and pass latch; abort beats terminal count, start beats abort in DONE.
  always_comb begin
    state_d   = state_q;
    pat_cnt_d = pat_cnt_q;
    pass_d    = pass_q;
    init      = 1'b0;
    step      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d   = ST_RUN;
          init      = 1'b1;
          pat_cnt_d = '0;
          pass_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else begin
          step      = 1'b1;
          pat_cnt_d = pat_cnt_q + CNT_W'(1);
          if (pat_cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            // The final response is absorbed on this same edge, so compare the post-step value.
            pass_d  = (misr_next(sig_q, bus.resp_in) == bus.golden);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_cnt_q <= pat_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  gate_bist_lfsr #(
    .W    (IN_W),
    .TAPS (LFSR_TAPS),
    .SEED (SEED_EFF)
  ) u_pat_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (step),
    .load (init),
    .xin  ('0),
    .q    (pat_q)
  );

  gate_bist_lfsr #(
    .W    (OUT_W),
    .TAPS (MISR_TAPS),
    .SEED ('0)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .en   (step),
    .load (init),
    .xin  (bus.resp_in),
    .q    (sig_q)
  );

  assign bus.pat_out   = pat_q;
  assign bus.signature = sig_q;
  assign bus.pat_cnt   = pat_cnt_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl: four instances with different run lengths.
// Latency: n/a.
// Backpressure: n/a.
module tb_gate_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  gate_bist_ctrl_if #(.CNT_W($clog2(21)))   b20 ();
  gate_bist_ctrl_if #(.CNT_W($clog2(4)))    b3  ();
  gate_bist_ctrl_if #(.CNT_W($clog2(1001))) bk  ();
  gate_bist_ctrl_if #(.CNT_W($clog2(2)))    b1  ();

  gate_bist_ctrl #(.PATTERNS(20))                       u20 (.clk(clk), .rst(rst), .bus(b20.slave));
  gate_bist_ctrl #(.PATTERNS(3), .SEED(21'h000000))     u3  (.clk(clk), .rst(rst), .bus(b3.slave));
  gate_bist_ctrl #(.PATTERNS(1000))                     uk  (.clk(clk), .rst(rst), .bus(bk.slave));
  gate_bist_ctrl #(.PATTERNS(1))                        u1  (.clk(clk), .rst(rst), .bus(b1.slave));

  // Reference rules written as plain integer arithmetic.
  function automatic logic [20:0] lfsr_nx(input logic [20:0] q);
    int v;
    v = int'(q);
    return 21'(((v << 1) & 32'h1FFFFF) | (((v >> 20) ^ (v >> 18)) & 1));
  endfunction

  function automatic logic [9:0] misr_nx(input logic [9:0] s, input logic [9:0] r);
    int v;
    v = int'(s);
    return 10'((((v << 1) & 32'h3FF) | (((v >> 9) ^ (v >> 6)) & 1)) ^ int'(r));
  endfunction

  // Stand-in combinational gate model for the loop-back run.
  function automatic logic [9:0] gate_model(input logic [20:0] n);
    logic [9:0] o;
    for (int i = 0; i < 10; i++) o[i] = n[2*i] ^ (n[2*i+1] & n[(3*i+5) % 21]);
    return o;
  endfunction

  logic       loop_en    = 1'b0;
  logic [9:0] stuck_mask = 10'h3FF;
  logic [9:0] bk_resp    = 10'h000;
  always_comb bk.resp_in = loop_en ? (gate_model(bk.pat_out) & stuck_mask) : bk_resp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({b20.pat_out, b20.signature, b20.pat_cnt, b20.busy, b20.done, b20.pass} !== {21'h1, 10'h0, 5'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_b20 got=%h exp=%h", {b20.pat_out, b20.signature, b20.pat_cnt, b20.busy, b20.done, b20.pass},
               {21'h1, 10'h0, 5'h0, 3'b000});
    end
    total++;
    if ({b3.pat_out, b3.signature, b3.pat_cnt, b3.busy, b3.done, b3.pass} !== {21'h1, 10'h0, 2'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_zero_seed got=%h exp=%h", {b3.pat_out, b3.signature, b3.pat_cnt, b3.busy, b3.done, b3.pass},
               {21'h1, 10'h0, 2'h0, 3'b000});
    end
    rst = 1'b0;
  endtask

  task automatic test_lfsr_seq();
    logic [20:0] exp_p;
    int n;
    b20.resp_in = '0;
    b20.golden  = '0;
    b20.start = 1'b1;
    tick();
    b20.start = 1'b0;
    n = 0;
    while (b20.busy === 1'b1 && n < 100) begin
      exp_p = (n < 19) ? (21'h1 << n) : 21'h080001;
      if (n < 20) begin
        total++;
        if (b20.pat_out !== exp_p) begin
          bad++;
          $display("FAIL lfsr_pat k=%0d got=%h exp=%h", n, b20.pat_out, exp_p);
        end
      end
      n++;
      tick();
    end
    total++;
    if (n != 20) begin
      bad++;
      $display("FAIL lfsr_busy_cycles got=%0d exp=20", n);
    end
    total++;
    if ({b20.done, b20.pat_cnt, b20.signature, b20.pass} !== {1'b1, 5'd20, 10'h0, 1'b1}) begin
      bad++;
      $display("FAIL lfsr_end got=%h exp=%h", {b20.done, b20.pat_cnt, b20.signature, b20.pass}, {1'b1, 5'd20, 10'h0, 1'b1});
    end
  endtask

  task automatic test_misr_known();
    logic [9:0] exp_s;
    b3.resp_in = 10'h001;
    for (int run = 0; run < 2; run++) begin
      b3.golden = (run == 0) ? 10'h007 : 10'h006;
      b3.start = 1'b1;
      tick();
      b3.start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        exp_s = 10'((1 << (k + 1)) - 1);
        total++;
        if (b3.signature !== exp_s) begin
          bad++;
          $display("FAIL misr_step run=%0d k=%0d got=%h exp=%h", run, k, b3.signature, exp_s);
        end
      end
      total++;
      if ({b3.done, b3.busy, b3.pat_cnt, b3.pass} !== {1'b1, 1'b0, 2'd3, (run == 0)}) begin
        bad++;
        $display("FAIL misr_end run=%0d got=%b exp=%b", run, {b3.done, b3.busy, b3.pat_cnt, b3.pass},
                 {1'b1, 1'b0, 2'd3, (run == 0)});
      end
    end
  endtask

  task automatic test_random_runs();
    logic [9:0]  r [20];
    logic [9:0]  s;
    logic [20:0] p;
    for (int run = 0; run < 3; run++) begin
      s = '0;
      for (int k = 0; k < 20; k++) begin
        r[k] = 10'($urandom);
        s = misr_nx(s, r[k]);
      end
      b20.golden = (run == 1) ? (s ^ 10'(1 << $urandom_range(9, 0))) : s;
      b20.start = 1'b1;
      tick();
      b20.start = 1'b0;
      s = '0;
      p = 21'h1;
      for (int k = 0; k < 20; k++) begin
        total++;
        if ({b20.busy, b20.pat_out, b20.pat_cnt, b20.signature} !== {1'b1, p, 5'(k), s}) begin
          bad++;
          $display("FAIL rand_cycle run=%0d k=%0d got=%h exp=%h", run, k,
                   {b20.busy, b20.pat_out, b20.pat_cnt, b20.signature}, {1'b1, p, 5'(k), s});
        end
        b20.resp_in = r[k];
        b20.start = (run == 2 && k == 7);
        tick();
        s = misr_nx(s, r[k]);
        p = lfsr_nx(p);
      end
      b20.start = 1'b0;
      total++;
      if ({b20.done, b20.busy, b20.pat_cnt, b20.signature, b20.pass} !== {1'b1, 1'b0, 5'd20, s, (run != 1)}) begin
        bad++;
        $display("FAIL rand_end run=%0d got=%h exp=%h", run, {b20.done, b20.busy, b20.pat_cnt, b20.signature, b20.pass},
                 {1'b1, 1'b0, 5'd20, s, (run != 1)});
      end
    end
    // abort outside RUN must leave DONE, pass and signature alone
    b20.abort = 1'b1;
    tick();
    b20.abort = 1'b0;
    total++;
    if ({b20.done, b20.busy, b20.signature, b20.pass} !== {1'b1, 1'b0, s, 1'b1}) begin
      bad++;
      $display("FAIL abort_in_done got=%h exp=%h", {b20.done, b20.busy, b20.signature, b20.pass}, {1'b1, 1'b0, s, 1'b1});
    end
  endtask

  task automatic test_restart();
    logic [9:0] r [20];
    logic [9:0] s;
    int n;
    s = '0;
    for (int k = 0; k < 20; k++) begin
      r[k] = 10'($urandom);
      s = misr_nx(s, r[k]);
    end
    b20.golden = s;
    for (int run = 0; run < 2; run++) begin
      b20.start = 1'b1;
      b20.abort = (run == 1);
      tick();
      b20.start = 1'b0;
      b20.abort = 1'b0;
      n = 0;
      while (b20.busy === 1'b1 && n < 100) begin
        b20.resp_in = r[(n < 20) ? n : 0];
        n++;
        tick();
      end
      total++;
      if (n != 20 || b20.signature !== s || b20.pass !== 1'b1) begin
        bad++;
        $display("FAIL restart run=%0d cycles=%0d sig=%h pass=%b exp cycles=20 sig=%h pass=1", run, n, b20.signature,
                 b20.pass, s);
      end
    end
  endtask

  task automatic test_abort();
    logic [9:0]  s;
    logic [20:0] p;
    s = '0;
    p = 21'h1;
    bk.golden = '0;
    bk.start = 1'b1;
    tick();
    bk.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bk_resp = 10'($urandom);
      s = misr_nx(s, bk_resp);
      p = lfsr_nx(p);
      tick();
    end
    bk_resp = 10'($urandom);
    bk.abort = 1'b1;
    tick();
    bk.abort = 1'b0;
    total++;
    if ({bk.busy, bk.done, bk.pass, bk.pat_cnt, bk.signature, bk.pat_out} !== {3'b000, 10'd5, s, p}) begin
      bad++;
      $display("FAIL abort_hold got=%h exp=%h", {bk.busy, bk.done, bk.pass, bk.pat_cnt, bk.signature, bk.pat_out},
               {3'b000, 10'd5, s, p});
    end
    bk.start = 1'b1;
    tick();
    bk.start = 1'b0;
    total++;
    if ({bk.busy, bk.pat_out, bk.signature, bk.pat_cnt} !== {1'b1, 21'h1, 10'h0, 10'd0}) begin
      bad++;
      $display("FAIL abort_reinit got=%h exp=%h", {bk.busy, bk.pat_out, bk.signature, bk.pat_cnt},
               {1'b1, 21'h1, 10'h0, 10'd0});
    end
    bk.abort = 1'b1;
    tick();
    bk.abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    b20.start = 1'b1;
    tick();
    b20.start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      b20.resp_in = 10'($urandom);
      tick();
    end
    rst = 1'b1;
    b20.start = 1'b1;
    tick();
    rst = 1'b0;
    b20.start = 1'b0;
    total++;
    if ({b20.pat_out, b20.signature, b20.pat_cnt, b20.busy, b20.done, b20.pass} !== {21'h1, 10'h0, 5'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_mid_run got=%h exp=%h", {b20.pat_out, b20.signature, b20.pat_cnt, b20.busy, b20.done, b20.pass},
               {21'h1, 10'h0, 5'h0, 3'b000});
    end
    tick();
    total++;
    if (b20.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_start_ignored busy got=%b exp=0", b20.busy);
    end
  endtask

  task automatic test_boundary_one();
    logic [9:0] r;
    r = 10'($urandom);
    b1.resp_in = r;
    b1.golden  = r;
    b1.abort   = 1'b0;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    total++;
    if ({b1.busy, b1.pat_out, b1.pat_cnt} !== {1'b1, 21'h1, 1'b0}) begin
      bad++;
      $display("FAIL one_run got=%h exp=%h", {b1.busy, b1.pat_out, b1.pat_cnt}, {1'b1, 21'h1, 1'b0});
    end
    tick();
    total++;
    if ({b1.done, b1.busy, b1.pat_cnt, b1.signature, b1.pass} !== {1'b1, 1'b0, 1'b1, r, 1'b1}) begin
      bad++;
      $display("FAIL one_done got=%h exp=%h", {b1.done, b1.busy, b1.pat_cnt, b1.signature, b1.pass},
               {1'b1, 1'b0, 1'b1, r, 1'b1});
    end
    // abort coinciding with terminal count: abort wins
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    b1.abort = 1'b1;
    tick();
    b1.abort = 1'b0;
    total++;
    if ({b1.done, b1.busy, b1.pat_cnt, b1.signature} !== {1'b0, 1'b0, 1'b0, 10'h0}) begin
      bad++;
      $display("FAIL one_abort_wins got=%h exp=%h", {b1.done, b1.busy, b1.pat_cnt, b1.signature},
               {1'b0, 1'b0, 1'b0, 10'h0});
    end
  endtask

  task automatic test_loopback();
    logic [9:0]  good;
    logic [9:0]  bad_sig;
    logic [20:0] p;
    int n;
    good = '0;
    bad_sig = '0;
    p = 21'h1;
    for (int k = 0; k < 1000; k++) begin
      good    = misr_nx(good, gate_model(p));
      bad_sig = misr_nx(bad_sig, gate_model(p) & ~10'h008);
      p = lfsr_nx(p);
    end
    loop_en   = 1'b1;
    bk.golden = good;
    for (int run = 0; run < 2; run++) begin
      stuck_mask = (run == 1) ? ~10'h008 : 10'h3FF;
      bk.start = 1'b1;
      tick();
      bk.start = 1'b0;
      n = 0;
      while (bk.busy === 1'b1 && n < 1100) begin
        n++;
        tick();
      end
      total++;
      if (n != 1000 || bk.done !== 1'b1 || bk.pat_cnt !== 10'd1000) begin
        bad++;
        $display("FAIL loop_len run=%0d cycles=%0d done=%b cnt=%0d exp 1000/1/1000", run, n, bk.done, bk.pat_cnt);
      end
      total++;
      if (bk.signature !== ((run == 1) ? bad_sig : good) || bk.pass !== ((run == 1) ? (bad_sig == good) : 1'b1)) begin
        bad++;
        $display("FAIL loop_sig run=%0d sig=%h pass=%b exp sig=%h pass=%b", run, bk.signature, bk.pass,
                 (run == 1) ? bad_sig : good, (run == 1) ? (bad_sig == good) : 1'b1);
      end
    end
    loop_en = 1'b0;
  endtask

  initial begin
    b20.start = 1'b0; b20.abort = 1'b0; b20.golden = '0; b20.resp_in = '0;
    b3.start  = 1'b0; b3.abort  = 1'b0; b3.golden  = '0; b3.resp_in  = '0;
    bk.start  = 1'b0; bk.abort  = 1'b0; bk.golden  = '0;
    b1.start  = 1'b0; b1.abort  = 1'b0; b1.golden  = '0; b1.resp_in  = '0;
    test_reset();
    test_lfsr_seq();
    test_misr_known();
    test_random_runs();
    test_restart();
    test_abort();
    test_reset_mid_run();
    test_boundary_one();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
